// File: rtl/paillier_result_collector.sv
// Gathers the N limbs of one Paillier ciphertext from the encrypt core into a wide result word.
// Define PAILLIER_COLLECT_TIMEOUT_EN to abort a burst after TIMEOUT idle cycles in COLLECT.
module paillier_result_collector #(
  parameter int K       = 128,
  parameter int N       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 task_req,
  input  logic [K-1:0]         enc_out_data,
  input  logic                 enc_out_valid,
  output logic [K*N-1:0]       res_data,
  output logic                 res_valid,
  input  logic                 res_ack,
  output logic                 busy,
  output logic [$clog2(N):0]   beat_cnt,
  output logic                 err_overflow,
  output logic                 err_timeout
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, ARMED, COLLECT, DONE} state_t;
  state_t state;

  logic [CW-1:0] next_cnt;
  assign next_cnt = beat_cnt + 1'b1;

  assign busy = (state == ARMED) || (state == COLLECT);

`ifdef PAILLIER_COLLECT_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;
`else
  assign err_timeout = 1'b0;
`endif

  // beat_cnt doubles as the write limb index; it stops at N because the last beat leaves COLLECT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      res_data     <= '0;
      res_valid    <= 1'b0;
      beat_cnt     <= '0;
      err_overflow <= 1'b0;
`ifdef PAILLIER_COLLECT_TIMEOUT_EN
      err_timeout  <= 1'b0;
      idle_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (task_req) begin
            state        <= ARMED;
            beat_cnt     <= '0;
            res_valid    <= 1'b0;
            err_overflow <= 1'b0;
`ifdef PAILLIER_COLLECT_TIMEOUT_EN
            err_timeout  <= 1'b0;
            idle_cnt     <= '0;
`endif
          end else begin
            if (enc_out_valid) begin
              err_overflow <= 1'b1;
            end
            if ((state == DONE) && res_ack) begin
              state     <= IDLE;
              res_valid <= 1'b0;
            end
          end
        end
        ARMED, COLLECT: begin
          if (enc_out_valid) begin
            res_data[beat_cnt*K +: K] <= enc_out_data;
            beat_cnt <= next_cnt;
`ifdef PAILLIER_COLLECT_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (beat_cnt == LAST_BEAT) begin
              state     <= DONE;
              res_valid <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
`ifdef PAILLIER_COLLECT_TIMEOUT_EN
          // only COLLECT is timed: an armed core may take arbitrarily long to produce its first limb
          else if (state == COLLECT) begin
            if (idle_cnt == IW'(TIMEOUT - 1)) begin
              err_timeout <= 1'b1;
              state       <= IDLE;
              beat_cnt    <= '0;
              res_valid   <= 1'b0;
              idle_cnt    <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
